// File: rtl/pll_seq.sv
// PLL bring-up sequencer: powers up the PLL, waits for a stable lock, then staggers the
// release of the memory and core domain resets. It also runs the CLKOUT0 divider-change handshake.
module pll_seq #(
   parameter int PWRUP_CYCLES = 32,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int RST_STAGGER  = 16,
   parameter int ODIV_DEFAULT = 36
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [6:0] pll_odsel0,
   output logic       rst_mem,
   output logic       rst_core,
   input  logic       cfg_req,
   input  logic [6:0] cfg_odiv,
   output logic       cfg_ack,
   output logic       cfg_err,
   output logic       cfg_busy,
   output logic       locked,
   output logic [3:0] retry_cnt
);

   localparam int PW_W = $clog2(PWRUP_CYCLES + 1);
   localparam int SB_W = $clog2(LOCK_STABLE + 1);
   localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int ST_W = $clog2(RST_STAGGER + 1);

   localparam logic [PW_W-1:0] PWRUP_LAST   = PW_W'(PWRUP_CYCLES - 1);
   localparam logic [SB_W-1:0] STABLE_LAST  = SB_W'(LOCK_STABLE - 1);
   localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [ST_W-1:0] STAGGER_LAST = ST_W'(RST_STAGGER - 1);

   typedef enum logic [1:0] {
      PWRUP     = 2'd0,
      WAIT_LOCK = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t          state_q;
   logic            lock_meta_q;
   logic            lock_s_q;
   logic [PW_W-1:0] pwrup_cnt_q;
   logic [SB_W-1:0] stable_cnt_q;
   logic [TO_W-1:0] timeout_cnt_q;
   logic [ST_W-1:0] stagger_cnt_q;
   logic [3:0]      retry_cnt_q;
   logic [6:0]      odsel_q;
   logic            pll_reset_q;
   logic            rst_mem_q;
   logic            rst_core_q;
   logic            locked_q;
   logic            busy_q;
   logic            ack_q;
   logic            err_q;
   logic            armed_q;
   logic            accept;

   // A request is taken only on a fresh assertion: armed_q records that cfg_req was seen low.
   assign accept = (state_q == RUN) && cfg_req && !busy_q && armed_q;

   // NOTE: every register, including the sync flops, is cleared by the synchronous reset
   // branch; all state updates are non-blocking so each branch reads pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= PWRUP;
         lock_meta_q   <= 1'b0;
         lock_s_q      <= 1'b0;
         pwrup_cnt_q   <= '0;
         stable_cnt_q  <= '0;
         timeout_cnt_q <= '0;
         stagger_cnt_q <= '0;
         retry_cnt_q   <= '0;
         odsel_q       <= 7'(ODIV_DEFAULT);
         pll_reset_q   <= 1'b1;
         rst_mem_q     <= 1'b1;
         rst_core_q    <= 1'b1;
         locked_q      <= 1'b0;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
         err_q         <= 1'b0;
         armed_q       <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock;
         lock_s_q    <= lock_meta_q;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;

         case (state_q)
            PWRUP: begin
               pll_reset_q <= 1'b1;
               rst_mem_q   <= 1'b1;
               rst_core_q  <= 1'b1;
               locked_q    <= 1'b0;
               if (pwrup_cnt_q == PWRUP_LAST) begin
                  state_q       <= WAIT_LOCK;
                  pll_reset_q   <= 1'b0;
                  pwrup_cnt_q   <= '0;
                  stable_cnt_q  <= '0;
                  timeout_cnt_q <= '0;
               end else begin
                  pwrup_cnt_q <= pwrup_cnt_q + PW_W'(1);
               end
            end

            WAIT_LOCK: begin
               if (lock_s_q && (stable_cnt_q == STABLE_LAST)) begin
                  state_q       <= RUN;
                  locked_q      <= 1'b1;
                  rst_mem_q     <= 1'b0;
                  stagger_cnt_q <= '0;
                  if (busy_q) begin
                     ack_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     armed_q <= 1'b0;
                  end
               end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                  state_q     <= PWRUP;
                  pll_reset_q <= 1'b1;
                  pwrup_cnt_q <= '0;
                  if (retry_cnt_q != 4'hF) begin
                     retry_cnt_q <= retry_cnt_q + 4'd1;
                  end
               end else begin
                  timeout_cnt_q <= timeout_cnt_q + TO_W'(1);
                  stable_cnt_q  <= lock_s_q ? stable_cnt_q + SB_W'(1) : '0;
               end
            end

            RUN: begin
               // Lock loss outranks a same-cycle request.
               if (!lock_s_q) begin
                  state_q       <= WAIT_LOCK;
                  locked_q      <= 1'b0;
                  rst_mem_q     <= 1'b1;
                  rst_core_q    <= 1'b1;
                  stable_cnt_q  <= '0;
                  timeout_cnt_q <= '0;
               end else if (accept) begin
                  armed_q <= 1'b0;
                  if (cfg_odiv < 7'd2) begin
                     ack_q <= 1'b1;
                     err_q <= 1'b1;
                  end else begin
                     odsel_q     <= cfg_odiv;
                     busy_q      <= 1'b1;
                     state_q     <= PWRUP;
                     pll_reset_q <= 1'b1;
                     pwrup_cnt_q <= '0;
                     rst_mem_q   <= 1'b1;
                     rst_core_q  <= 1'b1;
                     locked_q    <= 1'b0;
                  end
               end else if (rst_core_q) begin
                  if (stagger_cnt_q == STAGGER_LAST) begin
                     rst_core_q <= 1'b0;
                  end else begin
                     stagger_cnt_q <= stagger_cnt_q + ST_W'(1);
                  end
               end
            end

            default: state_q <= PWRUP;
         endcase

         if (!cfg_req) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign pll_reset  = pll_reset_q;
   assign pll_odsel0 = odsel_q;
   assign rst_mem    = rst_mem_q;
   assign rst_core   = rst_core_q;
   assign cfg_ack    = ack_q;
   assign cfg_err    = err_q;
   assign cfg_busy   = busy_q;
   assign locked     = locked_q;
   assign retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_pll_seq.sv
// Directed bench for pll_seq: boot, glitchy lock, lock loss, timeout retries, valid/invalid
// divider changes and reset during a reconfiguration, with hand-derived cycle counts.
module tb_pll_seq;

   localparam int PW = 4;
   localparam int LS = 8;
   localparam int LT = 64;
   localparam int RS = 3;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       pll_lock = 1'b0;
   logic       cfg_req  = 1'b0;
   logic [6:0] cfg_odiv = 7'd0;
   logic       pll_reset;
   logic [6:0] pll_odsel0;
   logic       rst_mem;
   logic       rst_core;
   logic       cfg_ack;
   logic       cfg_err;
   logic       cfg_busy;
   logic       locked;
   logic [3:0] retry_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int acks     = 0;

   always #5 clk = ~clk;

   pll_seq #(
      .PWRUP_CYCLES(PW),
      .LOCK_STABLE (LS),
      .LOCK_TIMEOUT(LT),
      .RST_STAGGER (RS),
      .ODIV_DEFAULT(36)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .pll_reset (pll_reset),
      .pll_odsel0(pll_odsel0),
      .rst_mem   (rst_mem),
      .rst_core  (rst_core),
      .cfg_req   (cfg_req),
      .cfg_odiv  (cfg_odiv),
      .cfg_ack   (cfg_ack),
      .cfg_err   (cfg_err),
      .cfg_busy  (cfg_busy),
      .locked    (locked),
      .retry_cnt (retry_cnt)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Lock rises now; RUN must appear on the 10th edge (2 sync + 8 stable), not the 9th.
   task automatic relock(input string tag);
      pll_lock = 1'b1;
      step(9);
      check({tag, "_early"}, 32'(locked), 32'd0);
      step(1);
      check({tag, "_locked"}, 32'(locked), 32'd1);
      check({tag, "_rst_mem"}, 32'(rst_mem), 32'd0);
      check({tag, "_pll_reset"}, 32'(pll_reset), 32'd0);
   endtask

   initial begin
      step(3);
      check("rst_pll_reset", 32'(pll_reset), 32'd1);
      check("rst_mem", 32'(rst_mem), 32'd1);
      check("rst_core", 32'(rst_core), 32'd1);
      check("rst_odsel", 32'(pll_odsel0), 32'd36);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_ack", 32'(cfg_ack), 32'd0);
      check("rst_err", 32'(cfg_err), 32'd0);
      check("rst_busy", 32'(cfg_busy), 32'd0);
      check("rst_retry", 32'(retry_cnt), 32'd0);

      // Boot
      reset = 1'b0;
      step(3);
      check("pwrup_hold", 32'(pll_reset), 32'd1);
      step(1);
      check("pwrup_release", 32'(pll_reset), 32'd0);
      check("pwrup_mem_held", 32'(rst_mem), 32'd1);
      step(6);
      relock("boot");
      step(2);
      check("stagger_hold", 32'(rst_core), 32'd1);
      step(1);
      check("stagger_release", 32'(rst_core), 32'd0);

      // Invalid divider request
      cfg_odiv = 7'd1;
      cfg_req  = 1'b1;
      step(1);
      check("inv_ack", 32'(cfg_ack), 32'd1);
      check("inv_err", 32'(cfg_err), 32'd1);
      check("inv_odsel", 32'(pll_odsel0), 32'd36);
      check("inv_locked", 32'(locked), 32'd1);
      check("inv_busy", 32'(cfg_busy), 32'd0);
      cfg_req = 1'b0;
      step(1);
      check("inv_ack_pulse", 32'(cfg_ack), 32'd0);
      check("inv_err_pulse", 32'(cfg_err), 32'd0);

      // Valid divider request
      cfg_odiv = 7'd27;
      cfg_req  = 1'b1;
      step(1);
      check("cfg_odsel", 32'(pll_odsel0), 32'd27);
      check("cfg_busy", 32'(cfg_busy), 32'd1);
      check("cfg_rst_mem", 32'(rst_mem), 32'd1);
      check("cfg_rst_core", 32'(rst_core), 32'd1);
      check("cfg_locked", 32'(locked), 32'd0);
      check("cfg_pll_reset", 32'(pll_reset), 32'd1);
      check("cfg_no_early_ack", 32'(cfg_ack), 32'd0);
      step(3);
      check("cfg_pwrup_hold", 32'(pll_reset), 32'd1);
      step(1);
      check("cfg_pwrup_release", 32'(pll_reset), 32'd0);
      step(7);
      check("cfg_relock_early", 32'(locked), 32'd0);
      check("cfg_busy_wait", 32'(cfg_busy), 32'd1);
      step(1);
      check("cfg_relock", 32'(locked), 32'd1);
      check("cfg_ack", 32'(cfg_ack), 32'd1);
      check("cfg_ack_err", 32'(cfg_err), 32'd0);
      check("cfg_busy_clear", 32'(cfg_busy), 32'd0);
      step(1);
      check("cfg_ack_pulse", 32'(cfg_ack), 32'd0);
      step(5);
      check("cfg_no_rearm_busy", 32'(cfg_busy), 32'd0);
      check("cfg_no_rearm_locked", 32'(locked), 32'd1);
      check("cfg_no_rearm_pll", 32'(pll_reset), 32'd0);
      check("cfg_core_released", 32'(rst_core), 32'd0);
      cfg_req = 1'b0;

      // Lock loss for 3 cycles
      pll_lock = 1'b0;
      step(2);
      check("loss_sync_delay", 32'(locked), 32'd1);
      step(1);
      check("loss_locked", 32'(locked), 32'd0);
      check("loss_rst_mem", 32'(rst_mem), 32'd1);
      check("loss_rst_core", 32'(rst_core), 32'd1);
      check("loss_pll_reset", 32'(pll_reset), 32'd0);
      relock("loss");

      // Glitchy lock: 5 high, 1 low, then high
      pll_lock = 1'b0;
      step(3);
      check("glitch_loss", 32'(locked), 32'd0);
      pll_lock = 1'b1;
      step(5);
      pll_lock = 1'b0;
      step(1);
      relock("glitch");

      // Timeouts and retry saturation
      pll_lock = 1'b0;
      step(3);
      check("to_loss", 32'(locked), 32'd0);
      step(LT - 1);
      check("to_pll_before", 32'(pll_reset), 32'd0);
      check("to_retry_before", 32'(retry_cnt), 32'd0);
      step(1);
      check("to_pll_reset", 32'(pll_reset), 32'd1);
      check("to_retry1", 32'(retry_cnt), 32'd1);
      check("to_odsel_kept", 32'(pll_odsel0), 32'd27);
      step(PW + LT);
      check("to_retry2", 32'(retry_cnt), 32'd2);
      check("to_retry2_pll", 32'(pll_reset), 32'd1);
      step((PW + LT) * 13);
      check("to_retry15", 32'(retry_cnt), 32'd15);
      step((PW + LT) * 2);
      check("to_retry_sat", 32'(retry_cnt), 32'd15);
      check("to_retry_sat_pll", 32'(pll_reset), 32'd1);

      // Reset during a reconfiguration
      pll_lock = 1'b1;
      step(20);
      check("abort_run", 32'(locked), 32'd1);
      cfg_odiv = 7'd50;
      cfg_req  = 1'b1;
      step(1);
      check("abort_busy", 32'(cfg_busy), 32'd1);
      check("abort_odsel_new", 32'(pll_odsel0), 32'd50);
      step(2);
      reset = 1'b1;
      step(1);
      check("abort_odsel", 32'(pll_odsel0), 32'd36);
      check("abort_busy_clr", 32'(cfg_busy), 32'd0);
      check("abort_retry", 32'(retry_cnt), 32'd0);
      check("abort_pll_reset", 32'(pll_reset), 32'd1);
      reset   = 1'b0;
      cfg_req = 1'b0;
      repeat (30) begin
         step(1);
         if (cfg_ack) acks++;
      end
      check("abort_no_ack", 32'(acks), 32'd0);
      check("abort_reboot", 32'(locked), 32'd1);
      check("abort_odsel_final", 32'(pll_odsel0), 32'd36);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pll_seq.md
PLL_SEQ -- requirements
Module: pll_seq

Interface
REQ-001 SHALL have parameter PWRUP_CYCLES, default 32: clk cycles pll_reset is held high in PWRUP.
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive synced-lock cycles required to enter RUN.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536: maximum WAIT_LOCK cycles before a PLL reset retry.
REQ-004 SHALL have parameter RST_STAGGER, default 16: RUN cycles between rst_mem release and rst_core release.
REQ-005 SHALL have parameter ODIV_DEFAULT, default 36: pll_odsel0 value after reset.
REQ-006 SHALL have port clk, input, 1: free-running 27 MHz reference clock (PLL input clock, not a PLL output).
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port pll_lock, input, 1: PLL LOCK, asynchronous to clk.
REQ-009 SHALL have port pll_reset, output, 1: PLL RESET, active-high.
REQ-010 SHALL have port pll_odsel0, output, 7: dynamic CLKOUT0 divider value, raw divide ratio.
REQ-011 SHALL have ports rst_mem and rst_core, output, 1 each: active-high resets for the SDRAM and core clock domains.
REQ-012 SHALL have ports cfg_req (in, 1), cfg_odiv (in, 7), cfg_ack (out, 1), cfg_err (out, 1) and cfg_busy (out, 1): the divider-change handshake.
REQ-013 SHALL have port locked, output, 1: high while in RUN.
REQ-014 SHALL have port retry_cnt, output, 4: count of lock timeouts, saturating at 15.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchronizer; lock_s is the second flop, and every lock decision uses lock_s only.
REQ-016 SHALL implement the FSM states PWRUP, WAIT_LOCK and RUN.
REQ-017 PWRUP SHALL hold pll_reset=1 and both domain resets high, then move to WAIT_LOCK with pll_reset=0 after exactly PWRUP_CYCLES cycles.
REQ-018 WAIT_LOCK SHALL keep a stable counter that increments while lock_s=1 and clears to 0 while lock_s=0.
REQ-019 WAIT_LOCK SHALL move to RUN when the stable counter reaches LOCK_STABLE-1 with lock_s=1.
REQ-020 WAIT_LOCK SHALL keep a timeout counter that counts every cycle spent in WAIT_LOCK.
REQ-021 When the timeout counter reaches LOCK_TIMEOUT-1 without entering RUN, the block SHALL go to PWRUP and increment retry_cnt, saturating at 15.
REQ-022 On the first RUN cycle, locked SHALL be 1 and rst_mem SHALL be 0.
REQ-023 rst_core SHALL deassert RST_STAGGER cycles after rst_mem deasserts.
REQ-024 If lock_s=0 in RUN, the next cycle SHALL have locked=0, rst_mem=1, rst_core=1 and state WAIT_LOCK with both counters cleared; pll_reset stays 0.
REQ-025 A request SHALL be accepted only when all hold: state is RUN, cfg_req=1, cfg_busy=0, and cfg_req was 0 at some cycle since the previous ack (edge-armed).
REQ-026 cfg_req SHALL be ignored in any other state; the requester holds cfg_req until ack.
REQ-027 On an accepted request with cfg_odiv<2: on the next cycle, cfg_ack=1 and cfg_err=1 for one cycle; pll_odsel0 and the state are unchanged.
REQ-028 On an accepted request with cfg_odiv>=2: on the next cycle, pll_odsel0=cfg_odiv, cfg_busy=1, both domain resets=1, locked=0, and the state is PWRUP.
REQ-029 For a valid request, on the first RUN cycle after relock: cfg_ack=1 for one cycle, cfg_err=0, and cfg_busy=0.
REQ-030 If lock_s=0 and cfg_req=1 in the same RUN cycle, lock loss SHALL take priority and the request is not accepted.
REQ-031 cfg_busy SHALL stay high through any lock losses or timeouts during the reconfiguration, until the ack.
REQ-032 cfg_ack and cfg_err SHALL be single-cycle pulses.
REQ-033 pll_odsel0 SHALL change only while pll_reset=1 or on the cycle PWRUP is entered.

Reset
REQ-034 While reset=1 the outputs SHALL be: pll_reset=1, rst_mem=1, rst_core=1, pll_odsel0=ODIV_DEFAULT, locked=0, cfg_ack=0, cfg_err=0, cfg_busy=0, retry_cnt=0.
REQ-035 While reset=1 the state SHALL be PWRUP with all counters and synchronizer flops at 0.
REQ-036 Reset asserted mid-reconfiguration SHALL abort it: no ack is issued, and pll_odsel0 returns to ODIV_DEFAULT.
REQ-037 The first cycle after reset deasserts SHALL be PWRUP cycle 0.

Verification (bench parameters: PWRUP_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, RST_STAGGER=3)
REQ-038 Boot: release reset, pll_lock rises 10 cycles later and stays high -> pll_reset low after 4 cycles; locked=1 and rst_mem=0 exactly 2+8 cycles after the lock rise (2 sync, 8 stable); rst_core=0 3 cycles after that.
REQ-039 Glitchy lock: lock high 5 cycles, low 1, then high -> stable count restarts; RUN is entered 8 cycles after the final rise plus sync delay.
REQ-040 Timeout: lock held low -> pll_reset reasserts after 64 WAIT_LOCK cycles with retry_cnt=1; after 16 timeouts retry_cnt stays 15.
REQ-041 Reconfig: in RUN, cfg_req=1 with cfg_odiv=27 -> next cycle pll_odsel0=27, busy=1, resets=1, pll_reset=1; after relock a 1-cycle cfg_ack, busy=0; holding req high issues no second accept.
REQ-042 Invalid reconfig: cfg_odiv=1 -> 1-cycle cfg_ack+cfg_err, pll_odsel0 stays 36, locked stays 1.
REQ-043 Lock loss: drop lock for 3 cycles in RUN -> resets assert 3 cycles after the drop (2 sync + 1); relock recovers without pll_reset; reset mid-reconfig -> odsel returns to 36, no ack.
